mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_FIRST, default 1: which port wins the first tie after reset (1 = data port, 0 = instruction port).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port if_req, input, 1: instruction fetch request, held until if_ack.
REQ-005 The block SHALL have port if_addr, input, 32: fetch byte address.
REQ-006 The block SHALL have port if_rdata, output, 32: fetched word, valid only while if_ack=1.
REQ-007 The block SHALL have port if_ack, output, 1: one-cycle fetch completion pulse.
REQ-008 The block SHALL have the following data-port ports: d_req in 1; d_we in 1; d_addr in 32; d_wdata in 32; d_size in 2 (00 byte, 01 half, 10/11 word); d_sign in 1.
REQ-009 The block SHALL have outputs d_rdata out 32, d_ack out 1 (one-cycle pulse) and d_err out 1 (misalign flag, valid with d_ack).
REQ-010 The block SHALL have the following memory-side ports: m_addr out 32; m_wdata out 32; m_we out 1; m_be out 4; m_sign out 1; m_rdata in 32 (combinational read).

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and DONE; it transitions IDLE->ACCESS when any request is present, ACCESS->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-012 In IDLE, the block SHALL grant one requester, latch its address, we, size, sign and wdata, and record the granted port.
REQ-013 With a single request pending, that request SHALL be granted; with both pending, the port not granted last SHALL be granted (round-robin).
REQ-014 In ACCESS, m_addr, m_wdata, m_be, m_sign and m_we SHALL be driven from the latched values, and m_rdata SHALL be registered at the end of the cycle.
REQ-015 m_we SHALL be 1 for exactly one cycle (ACCESS) per write; it SHALL never be asserted for a fetch.
REQ-016 A fetch SHALL drive m_be=1111 and m_sign=0.
REQ-017 Data-port m_be SHALL be: word 1111; half with addr[1]=0 -> 0011, addr[1]=1 -> 1100; byte with addr[1:0] = 00/01/10/11 -> 0001/0010/0100/1000.
REQ-018 m_wdata SHALL pass d_wdata unshifted; the memory performs lane placement and extension.
REQ-019 In DONE, exactly one of if_ack or d_ack SHALL be 1 and the corresponding rdata SHALL hold the registered word; writes SHALL return d_rdata=0.
REQ-020 The latency from req sampled in IDLE to ack SHALL be 2 cycles, and the throughput SHALL be one access per 3 cycles.
REQ-021 Requests SHALL be ignored in ACCESS and DONE; a req still high in the cycle after its ack SHALL be treated as a new request.
REQ-022 Outside ACCESS, memory outputs SHALL be m_addr=0, m_we=0, m_be=0000, m_sign=0, m_wdata=0; ack and err outputs SHALL be 0 outside DONE.

Reset
REQ-023 When rst=1 at a clock edge, the state SHALL go to IDLE, all outputs SHALL go to 0, and the last-grant pointer SHALL be set so that DATA_FIRST decides the first tie.
REQ-024 A reset asserted in ACCESS or DONE SHALL abort the access with no ack, and m_we SHALL be 0 from the next cycle.

Configuration
REQ-025 When MEM_ARB_MISALIGN_CHECK_EN is defined, a data access with half and addr[0]=1, or word and addr[1:0]!=00, SHALL keep m_we=0 and m_be=0000 in ACCESS and SHALL complete with d_ack=1, d_err=1, d_rdata=0 in DONE, with the same latency.
REQ-026 When MEM_ARB_MISALIGN_CHECK_EN is undefined, d_err SHALL be tied to 0, addr low bits not used by REQ-017 SHALL be ignored, and the access SHALL proceed normally.

Verification
REQ-027 The bench SHALL cover: reset, then if_req=1, if_addr=0x3000, m_rdata=0x20080005 -> m_be=1111 at cycle+1, and if_ack=1 with if_rdata=0x20080005 at cycle+2.
REQ-028 The bench SHALL cover: both req held, DATA_FIRST=1 -> grant order data, instr, data, instr, with acks 3 cycles apart.
REQ-029 The bench SHALL cover: d_we=1, d_size=00, d_addr=0x0000_0006, d_wdata=0xAB -> one-cycle m_we=1, m_be=0100, m_addr=0x6, then d_ack=1 and d_rdata=0.
REQ-030 The bench SHALL cover: half read with d_addr=0x2, d_sign=1 -> m_be=1100 and m_sign=1, and d_rdata equals m_rdata sampled in ACCESS.
REQ-031 The bench SHALL cover: rst pulsed during ACCESS of a write -> no ack, m_we=0 next cycle, and the next tie is granted to data.
REQ-032 The bench SHALL cover, with MEM_ARB_MISALIGN_CHECK_EN defined: word write to 0x5 -> m_we never 1, and d_ack=1 with d_err=1 at cycle+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single-cycle memory.
// Optional misalignment trapping on the data port: define MEM_ARB_MISALIGN_CHECK_EN.
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic        m_sign,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;
  logic   last_data_r;
  logic   gnt_data_r;
  logic   we_r;
  logic   err_r;
  logic   pick_data_s;
  logic   any_req_s;
  logic   d_mis_s;
  logic [3:0] d_be_s;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00: begin
        case (lo)
          2'b00:   be = 4'b0001;
          2'b01:   be = 4'b0010;
          2'b10:   be = 4'b0100;
          2'b11:   be = 4'b1000;
          default: be = 4'b0000;
        endcase
      end
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Grant selection: on a tie the port not served last wins.
  always_comb begin
    any_req_s   = if_req | d_req;
    pick_data_s = d_req & (~if_req | ~last_data_r);
    d_be_s      = lane_be(d_size, d_addr[1:0]);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    d_mis_s     = misaligned(d_size, d_addr[1:0]);
`else
    d_mis_s     = 1'b0;
`endif
  end

  // Access sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_data_r <= ~DATA_FIRST;
      gnt_data_r  <= 1'b0;
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      if_rdata    <= 32'h0;
      if_ack      <= 1'b0;
      d_rdata     <= 32'h0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      m_addr      <= 32'h0;
      m_wdata     <= 32'h0;
      m_we        <= 1'b0;
      m_be        <= 4'b0000;
      m_sign      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r     <= ACCESS;
            gnt_data_r  <= pick_data_s;
            last_data_r <= pick_data_s;
            if (pick_data_s) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_we    <= d_we & ~d_mis_s;
              m_be    <= d_mis_s ? 4'b0000 : d_be_s;
              m_sign  <= d_sign;
              we_r    <= d_we;
              err_r   <= d_mis_s;
            end else begin
              m_addr  <= if_addr;
              m_wdata <= 32'h0;
              m_we    <= 1'b0;
              m_be    <= 4'b1111;
              m_sign  <= 1'b0;
              we_r    <= 1'b0;
              err_r   <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r <= DONE;
          m_addr  <= 32'h0;
          m_wdata <= 32'h0;
          m_we    <= 1'b0;
          m_be    <= 4'b0000;
          m_sign  <= 1'b0;
          if (gnt_data_r) begin
            d_ack   <= 1'b1;
            d_err   <= err_r;
            d_rdata <= (we_r | err_r) ? 32'h0 : m_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= m_rdata;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          if_ack   <= 1'b0;
          if_rdata <= 32'h0;
          d_ack    <= 1'b0;
          d_err    <= 1'b0;
          d_rdata  <= 32'h0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (DATA_FIRST=1).
// Also honours MEM_ARB_MISALIGN_CHECK_EN for the misaligned-write case.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  logic        m_sign;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_be(m_be), .m_sign(m_sign),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  lane_size [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
  logic [31:0] lane_addr [5] = '{32'h10, 32'h11, 32'h13, 32'h20, 32'h30};
  logic [3:0]  lane_be   [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1111};

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'b00; d_sign = 1'b0; m_rdata = 32'h0;
    step(); step();
    check_value("rst_if_ack", {31'h0, if_ack}, 32'h0);
    check_value("rst_d_ack", {31'h0, d_ack}, 32'h0);
    check_value("rst_m_we", {31'h0, m_we}, 32'h0);
    check_value("rst_m_be", {28'h0, m_be}, 32'h0);
    check_value("rst_m_addr", m_addr, 32'h0);

    // single fetch
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h3000; m_rdata = 32'h2008_0005;
    step();
    check_value("fetch_m_be", {28'h0, m_be}, 32'hF);
    check_value("fetch_m_addr", m_addr, 32'h3000);
    check_value("fetch_m_we", {31'h0, m_we}, 32'h0);
    check_value("fetch_ack_early", {31'h0, if_ack}, 32'h0);
    step();
    check_value("fetch_ack", {31'h0, if_ack}, 32'h1);
    check_value("fetch_rdata", if_rdata, 32'h2008_0005);
    check_value("fetch_be_done", {28'h0, m_be}, 32'h0);
    if_req = 1'b0;
    step();
    check_value("fetch_ack_drop", {31'h0, if_ack}, 32'h0);

    // round robin with both held
    rst = 1'b1; step(); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h4000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    d_size = 2'b10; m_rdata = 32'h1234_5678;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_value($sformatf("rr_d_ack_%0d", k), {31'h0, d_ack}, (k == 2 || k == 8) ? 32'h1 : 32'h0);
      check_value($sformatf("rr_if_ack_%0d", k), {31'h0, if_ack}, (k == 5 || k == 11) ? 32'h1 : 32'h0);
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // byte write
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h6; d_wdata = 32'hAB; m_rdata = 32'hDEAD_BEEF;
    step();
    check_value("bw_m_we", {31'h0, m_we}, 32'h1);
    check_value("bw_m_be", {28'h0, m_be}, 32'h4);
    check_value("bw_m_addr", m_addr, 32'h6);
    check_value("bw_m_wdata", m_wdata, 32'hAB);
    d_req = 1'b0;
    step();
    check_value("bw_m_we_off", {31'h0, m_we}, 32'h0);
    check_value("bw_d_ack", {31'h0, d_ack}, 32'h1);
    check_value("bw_d_rdata", d_rdata, 32'h0);
    step();
    check_value("bw_ack_drop", {31'h0, d_ack}, 32'h0);

    // signed half read at addr 2
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 32'h2; d_sign = 1'b1; m_rdata = 32'hFFFF_8001;
    step();
    check_value("hr_m_be", {28'h0, m_be}, 32'hC);
    check_value("hr_m_sign", {31'h0, m_sign}, 32'h1);
    d_req = 1'b0; m_rdata = 32'h8001_1234;
    step();
    check_value("hr_d_ack", {31'h0, d_ack}, 32'h1);
    check_value("hr_d_rdata", d_rdata, 32'h8001_1234);
    check_value("hr_d_err", {31'h0, d_err}, 32'h0);
    step();
    d_sign = 1'b0;

    // lane table
    for (int i = 0; i < 5; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_size = lane_size[i]; d_addr = lane_addr[i];
      step();
      check_value($sformatf("lane_be_%0d", i), {28'h0, m_be}, {28'h0, lane_be[i]});
      d_req = 1'b0;
      step(); step();
    end

    // reset during a write's ACCESS
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h40; d_wdata = 32'h55;
    step();
    check_value("ra_m_we", {31'h0, m_we}, 32'h1);
    rst = 1'b1; d_req = 1'b0;
    step();
    check_value("ra_m_we_off", {31'h0, m_we}, 32'h0);
    check_value("ra_no_ack", {31'h0, d_ack}, 32'h0);
    rst = 1'b0;
    step();
    check_value("ra_no_ack2", {31'h0, d_ack}, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; if_req = 1'b1; if_addr = 32'h9000;
    step();
    check_value("ra_tie_data", m_addr, 32'h80);
    d_req = 1'b0; if_req = 1'b0;
    step(); step();

    // word write to 0x5
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h5; d_wdata = 32'h77;
    step();
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    check_value("mis_m_we", {31'h0, m_we}, 32'h0);
    check_value("mis_m_be", {28'h0, m_be}, 32'h0);
`else
    check_value("mis_m_we", {31'h0, m_we}, 32'h1);
    check_value("mis_m_be", {28'h0, m_be}, 32'hF);
`endif
    d_req = 1'b0;
    step();
    check_value("mis_m_we_done", {31'h0, m_we}, 32'h0);
    check_value("mis_d_ack", {31'h0, d_ack}, 32'h1);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    check_value("mis_d_err", {31'h0, d_err}, 32'h1);
`else
    check_value("mis_d_err", {31'h0, d_err}, 32'h0);
`endif
    check_value("mis_d_rdata", d_rdata, 32'h0);
    step();
    check_value("mis_err_drop", {31'h0, d_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
